sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 41 ++++
 rtl/sync_fifo_param.sv | 112 +++++++++++
 tb/tb_sync_fifo_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 16;

  // Occupancy needs one extra bit so that count == DEPTH is representable.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port and one synchronous read port with a
// resettable output register that holds its value between reads.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with registered read data, occupancy
// count, threshold flags and sticky overflow/underflow error flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2,
  localparam int unsigned CW    = count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvlC = CW'(AF_LVL);
  localparam logic [CW-1:0] AeLvlC = CW'(AE_LVL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
  end
  if (AE_LVL >= AF_LVL) begin : gen_bad_levels
    $error("sync_fifo_param: AE_LVL must be below AF_LVL");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Flags decode registered occupancy only.
  always_comb begin
    full         = (count_q == DepthC);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfLvlC);
    almost_empty = (count_q <= AeLvlC);
  end

  // Acceptance, pointer/count next state and sticky error flags (set wins over clear).
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d  = (wr_en && full)  || (overflow_q  && !clr_err);
    underflow_d = (rd_en && empty) || (underflow_q && !clr_err);
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a queue-based occupancy model checked on every
// falling edge, plus directed sequences with literal expectations.
module tb_sync_fifo_param;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_LVL = 14;
  localparam int unsigned AE_LVL = 2;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              clr_err;
  logic              overflow;
  logic              underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: contents as a queue plus expected registered outputs.
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic              m_ovf;
  logic              m_udf;

  sync_fifo_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // Apply one clock edge of the FIFO rules to the model, using pre-edge state.
  task automatic model_step();
    bit was_full;
    bit was_empty;
    was_full   = (mq.size() == DEPTH);
    was_empty  = (mq.size() == 0);
    m_ovf      = (wr_en && was_full) || (m_ovf && !clr_err);
    m_udf      = (rd_en && was_empty) || (m_udf && !clr_err);
    m_rd_valid = rd_en && !was_empty;
    if (m_rd_valid) m_rd_data = mq.pop_front();
    if (wr_en && !was_full) mq.push_back(wr_data);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Continuous comparison against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("count",        32'(count),        32'(mq.size()));
      chk("full",         32'(full),         32'(mq.size() == DEPTH));
      chk("empty",        32'(empty),        32'(mq.size() == 0));
      chk("almost_full",  32'(almost_full),  32'(mq.size() >= AF_LVL));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE_LVL));
      chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
      chk("rd_data",      rd_data,           m_rd_data);
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_udf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",  32'(count),        32'd0);
    chk("rst_empty",  32'(empty),        32'd1);
    chk("rst_ae",     32'(almost_empty), 32'd1);
    chk("rst_full",   32'(full),         32'd0);
    chk("rst_af",     32'(almost_full),  32'd0);
    chk("rst_rdv",    32'(rd_valid),     32'd0);
    rst_n = 1'b1;
    cyc();

    // Fill with 0x11..0x20.
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h11 + 32'(i);
      cyc();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af",    32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;
    chk("fill_full", 32'(full), 32'd1);

    // Write while full is dropped and flagged.
    wr_en   = 1'b1;
    wr_data = 32'hDEAD;
    cyc();
    wr_en = 1'b0;
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    cyc();
    cyc();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain in order, one cycle latency.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      cyc();
      chk("drain_rdv",  32'(rd_valid), 32'd1);
      chk("drain_data", rd_data,       32'h11 + 32'(i));
    end
    rd_en = 1'b0;
    cyc();
    chk("drain_rdv_off", 32'(rd_valid), 32'd0);
    chk("drain_empty",   32'(empty),    32'd1);

    // Read while empty.
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("udf_rdv",  32'(rd_valid),  32'd0);
    chk("udf_hold", rd_data,        32'h20);
    chk("udf_set",  32'(underflow), 32'd1);
    // Clear coincident with a new underflow leaves it set.
    rd_en   = 1'b1;
    clr_err = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("udf_setwins", 32'(underflow), 32'd1);
    cyc();
    clr_err = 1'b0;
    chk("udf_clr", 32'(underflow), 32'd0);

    // Read+write on empty: write only, no bypass.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'h77;
    cyc();
    rd_en = 1'b0;
    chk("empty_rw_rdv",   32'(rd_valid),  32'd0);
    chk("empty_rw_count", 32'(count),     32'd1);
    chk("empty_rw_udf",   32'(underflow), 32'd1);
    wr_en   = 1'b0;
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;

    // Bring occupancy to 8.
    for (int i = 0; i < 7; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h100 + 32'(i);
      cyc();
    end
    chk("steady_start", 32'(count), 32'd8);

    // 40 cycles of simultaneous read/write across several pointer wraps.
    for (int k = 0; k < 40; k++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 32'h200 + 32'(k);
      cyc();
      chk("steady_count", 32'(count),    32'd8);
      chk("steady_rdv",   32'(rd_valid), 32'd1);
      chk("steady_data",  rd_data,
          (k == 0) ? 32'h77 : (k < 8) ? 32'h100 + 32'(k - 1) : 32'h200 + 32'(k - 8));
    end
    rd_en = 1'b0;

    // Fill to full, then read+write: read wins, write rejected.
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h300 + 32'(i);
      cyc();
    end
    chk("full_again", 32'(full), 32'd1);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'hBEEF;
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("full_rw_count", 32'(count),    32'd15);
    chk("full_rw_rdv",   32'(rd_valid), 32'd1);
    chk("full_rw_data",  rd_data,       32'h220);
    chk("full_rw_ovf",   32'(overflow), 32'd1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;

    // Down to 5 entries, then asynchronous reset mid-cycle.
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      cyc();
    end
    rd_en = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", 32'(count),    32'd0);
    chk("arst_empty", 32'(empty),    32'd1);
    chk("arst_rdv",   32'(rd_valid), 32'd0);
    chk("arst_data",  rd_data,       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    wr_en   = 1'b1;
    wr_data = 32'hA5;
    cyc();
    wr_en = 1'b0;
    chk("post_rst_count", 32'(count), 32'd1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("post_rst_rdv",  32'(rd_valid), 32'd1);
    chk("post_rst_data", rd_data,       32'hA5);
    cyc();
    chk("post_rst_empty", 32'(empty), 32'd1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
